// File: rtl/manual_drive_ctrl.sv
// Manual-drive sequencer: pedals/gear/steering -> drive FSM, registered chassis
// commands, blinking indicators, power-off request pulse and mileage counter.
module manual_drive_ctrl #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int MILE_DIV  = 50_000_000,
  parameter int MILE_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              reverse,
  input  logic              brake,
  input  logic              clutch,
  input  logic              throttle,
  input  logic              left,
  input  logic              right,
  output logic [1:0]        state,
  output logic              power_off,
  output logic              brake_out,
  output logic              move_forward,
  output logic              move_backward,
  output logic              turn_left,
  output logic              turn_right,
  output logic              left_led,
  output logic              right_led,
  output logic [MILE_W-1:0] mileage
);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int MW = (MILE_DIV > 1) ? $clog2(MILE_DIV) : 1;

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } st_t;

  st_t           st_q, st_d;
  logic          pwr_d, rev_q, rev_chg;
  logic [BW-1:0] blink_cnt;
  logic          phase, phase_d, blink_wrap;
  logic [MW-1:0] mile_cnt;
  logic          mile_hit;
  logic          mf_d, mb_d, tl_d, tr_d, ll_d, rl_d, bo_d;

  assign state   = st_q;
  assign rev_chg = reverse ^ rev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= NOT_STARTING;
    else     st_q <= st_d;
  end

  // priority inside each state: power-off, then brake, then pedals
  always_comb begin
    st_d  = st_q;
    pwr_d = 1'b0;
    if (!enable) begin
      st_d = NOT_STARTING;
    end else begin
      case (st_q)
        NOT_STARTING: begin
          if (throttle && !clutch)               pwr_d = 1'b1;
          else if (throttle && clutch && !brake) st_d  = STARTING;
        end
        STARTING: begin
          if (brake)                     st_d = NOT_STARTING;
          else if (throttle && !clutch)  st_d = MOVING;
        end
        MOVING: begin
          if (rev_chg && !clutch) begin
            pwr_d = 1'b1;
            st_d  = NOT_STARTING;
          end else if (brake)            st_d = NOT_STARTING;
          else if (!throttle || clutch)  st_d = STARTING;
        end
        default: st_d = NOT_STARTING;
      endcase
    end
  end

  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
  assign phase_d    = enable & (phase ^ blink_wrap);
  assign mile_hit   = (mile_cnt == MW'(MILE_DIV - 1));

  // commands decode the next state so they move on the same edge as state
  always_comb begin
    mf_d = enable && (st_d == MOVING) && !reverse;
    mb_d = enable && (st_d == MOVING) &&  reverse;
    tl_d = enable && left  && !right && (st_d != NOT_STARTING);
    tr_d = enable && right && !left  && (st_d != NOT_STARTING);
    ll_d = enable && left  && phase_d;
    rl_d = enable && right && phase_d;
    bo_d = enable && brake;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q         <= 1'b0;
      power_off     <= 1'b0;
      brake_out     <= 1'b0;
      move_forward  <= 1'b0;
      move_backward <= 1'b0;
      turn_left     <= 1'b0;
      turn_right    <= 1'b0;
      left_led      <= 1'b0;
      right_led     <= 1'b0;
      blink_cnt     <= '0;
      phase         <= 1'b0;
    end else begin
      rev_q         <= reverse;
      power_off     <= pwr_d;
      brake_out     <= bo_d;
      move_forward  <= mf_d;
      move_backward <= mb_d;
      turn_left     <= tl_d;
      turn_right    <= tr_d;
      left_led      <= ll_d;
      right_led     <= rl_d;
      phase         <= phase_d;
      if (!enable || blink_wrap) blink_cnt <= '0;
      else                       blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // distance only accrues while actually moving; STARTING pauses the divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mile_cnt <= '0;
      mileage  <= '0;
    end else if (enable && st_q == MOVING) begin
      if (mile_hit) begin
        mile_cnt <= '0;
        mileage  <= mileage + MILE_W'(1);
      end else begin
        mile_cnt <= mile_cnt + MW'(1);
      end
    end else if (!(enable && st_q == STARTING)) begin
      mile_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Randomised + directed bench for manual_drive_ctrl against a cycle-level
// behavioural model built from the drive rules.
module tb_manual_drive_ctrl;
  localparam int BD = 4, MD = 3, MWD = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic enable = 0, reverse = 0, brake = 0, clutch = 0, throttle = 0, left = 0, right = 0;
  logic [1:0] state;
  logic power_off, brake_out, move_forward, move_backward, turn_left, turn_right;
  logic left_led, right_led;
  logic [MWD-1:0] mileage;

  int n_cmp = 0, n_err = 0;

  // model state
  int m_st, m_revq, m_bcnt, m_phase, m_mdiv, m_mile;
  int e_po, e_bo, e_mf, e_mb, e_tl, e_tr, e_ll, e_rl;

  manual_drive_ctrl #(.BLINK_DIV(BD), .MILE_DIV(MD), .MILE_W(MWD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .reverse(reverse), .brake(brake),
    .clutch(clutch), .throttle(throttle), .left(left), .right(right),
    .state(state), .power_off(power_off), .brake_out(brake_out),
    .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .left_led(left_led), .right_led(right_led), .mileage(mileage));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_revq = 0; m_bcnt = 0; m_phase = 0; m_mdiv = 0; m_mile = 0;
    e_po = 0; e_bo = 0; e_mf = 0; e_mb = 0; e_tl = 0; e_tr = 0; e_ll = 0; e_rl = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 16'(state), 16'(m_st));
    chk({tag, ".power_off"}, 16'(power_off), 16'(e_po));
    chk({tag, ".brake_out"}, 16'(brake_out), 16'(e_bo));
    chk({tag, ".fwd"}, 16'(move_forward), 16'(e_mf));
    chk({tag, ".bwd"}, 16'(move_backward), 16'(e_mb));
    chk({tag, ".tl"}, 16'(turn_left), 16'(e_tl));
    chk({tag, ".tr"}, 16'(turn_right), 16'(e_tr));
    chk({tag, ".lled"}, 16'(left_led), 16'(e_ll));
    chk({tag, ".rled"}, 16'(right_led), 16'(e_rl));
    chk({tag, ".mileage"}, 16'(mileage), 16'(m_mile));
  endtask

  // one clock: predict from the drive rules, clock, compare
  task automatic cyc(input bit en, rv, br, cl, th, l, r, input string tag);
    int ns, po;
    bit chg;
    enable = en; reverse = rv; brake = br; clutch = cl; throttle = th; left = l; right = r;
    chg = (int'(rv) != m_revq);
    ns = m_st; po = 0;
    if (!en) ns = 0;
    else if (m_st == 0) begin
      if (th && !cl) po = 1;
      else if (th && cl && !br) ns = 1;
    end else if (m_st == 1) begin
      if (br) ns = 0;
      else if (th && !cl) ns = 2;
    end else begin
      if (chg && !cl) begin po = 1; ns = 0; end
      else if (br) ns = 0;
      else if (!th || cl) ns = 1;
    end
    if (en && m_st == 2) begin
      if (m_mdiv == MD - 1) begin m_mdiv = 0; m_mile = (m_mile + 1) % (1 << MWD); end
      else m_mdiv++;
    end else if (!(en && m_st == 1)) m_mdiv = 0;
    if (!en) begin m_bcnt = 0; m_phase = 0; end
    else if (m_bcnt == BD - 1) begin m_bcnt = 0; m_phase ^= 1; end
    else m_bcnt++;
    e_po = po;
    e_bo = en && br;
    e_mf = en && ns == 2 && !rv;
    e_mb = en && ns == 2 && rv;
    e_tl = en && l && !r && ns != 0;
    e_tr = en && r && !l && ns != 0;
    e_ll = en && l && m_phase;
    e_rl = en && r && m_phase;
    m_st = ns; m_revq = rv;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1; #1;
    model_reset();
    check_all(tag);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    bit en, rv, br, cl, th, l, r;
    model_reset();
    #13;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // start up, then drive forward
    cyc(1,0,0,1,1,0,0, "start");
    chk("start.state01", 16'(state), 16'd1);
    cyc(1,0,0,0,1,0,0, "move");
    chk("move.state10", 16'(state), 16'd2);
    chk("move.fwd1", 16'(move_forward), 16'd1);
    // reverse toggle without clutch -> power_off, back to idle
    cyc(1,1,0,0,1,0,0, "revpo");
    chk("revpo.pulse", 16'(power_off), 16'd1);
    cyc(1,1,0,0,0,0,0, "revpo2");
    chk("revpo2.pulse_gone", 16'(power_off), 16'd0);
    // idle throttle without clutch -> power_off, stay idle
    cyc(1,1,0,0,1,0,0, "idlepo");
    cyc(1,1,0,0,0,0,0, "idlepo2");
    // forward moving, then reverse toggle with clutch held -> STARTING
    cyc(1,0,0,1,1,0,0, "s2");
    cyc(1,0,0,0,1,0,0, "m2");
    cyc(1,1,0,1,1,0,0, "revcl");
    chk("revcl.state01", 16'(state), 16'd1);
    cyc(1,1,0,0,1,0,0, "remove");
    chk("remove.bwd1", 16'(move_backward), 16'd1);
    // brake while moving with throttle
    cyc(1,1,1,0,1,0,0, "brake");
    chk("brake.state00", 16'(state), 16'd0);
    // steering and blinking in idle and moving
    for (int i = 0; i < 10; i++) cyc(1,0,0,0,0,1,0, "blinkL");
    for (int i = 0; i < 6; i++) cyc(1,0,0,0,0,1,1, "blinkLR");
    cyc(1,0,0,1,1,1,1, "steer_s");
    for (int i = 0; i < 4; i++) cyc(1,0,0,1,0,1,0, "steerL");
    // mileage wrap over a long MOVING stretch, then hold in STARTING
    cyc(1,0,0,0,1,0,0, "mm");
    for (int i = 0; i < 12; i++) cyc(1,0,0,0,1,0,1, "mile");
    for (int i = 0; i < 4; i++) cyc(1,0,0,1,1,0,0, "hold");
    cyc(1,0,0,0,1,0,0, "mm2");
    cyc(1,0,0,0,1,0,0, "mm3");
    async_reset("midrst");
    // enable drop
    cyc(1,0,0,1,1,1,0, "en_s");
    cyc(0,0,0,1,1,1,0, "en_off");

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 49) != 0);
      rv = ($urandom_range(0, 19) == 0) ? ~reverse : reverse;
      br = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 2) == 0);
      th = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      cyc(en, rv, br, cl, th, l, r, "rnd");
      if ($urandom_range(0, 499) == 0) async_reset("rndrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/manual_drive_ctrl.md
Name: manual_drive_ctrl

Overview:
- Sequencing controller for manual driving mode: turns the raw cockpit controls (throttle, clutch, brake, reverse, left, right) into a drive state machine.
- Produces registered motion/turn commands for the chassis, turn-signal blink outputs, a power-off request pulse, and a travelled-distance counter.
- Sits between the mode selector (which drives enable) and the chassis/UART command path.
- All control inputs arrive already synchronised and debounced.

Parameters:
- BLINK_DIV, 25_000_000, clk cycles per turn-LED toggle.
- MILE_DIV, 50_000_000, clk cycles in MOVING per mileage increment.
- MILE_W, 16, mileage counter width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  manual mode selected and power on.
- reverse  input  1  gear lever level: 1 = reverse, 0 = forward.
- brake  input  1  brake pedal.
- clutch  input  1  clutch pedal.
- throttle  input  1  throttle pedal.
- left  input  1  steer left.
- right  input  1  steer right.
- state  output  2  00 NOT_STARTING, 01 STARTING, 10 MOVING (11 unused).
- power_off  output  1  one-cycle request to global power FSM.
- brake_out  output  1  brake command to chassis.
- move_forward  output  1  forward drive command.
- move_backward  output  1  backward drive command.
- turn_left  output  1  left steer command.
- turn_right  output  1  right steer command.
- left_led  output  1  left indicator (blinking).
- right_led  output  1  right indicator (blinking).
- mileage  output  MILE_W  distance units travelled.

Behaviour:
- Reset (async, rst=1): state=NOT_STARTING; all 1-bit outputs 0; mileage=0; blink and mile dividers 0; rev_q=0.
- rev_q is registered every cycle from reverse. rev_chg = reverse ^ rev_q.
- enable=0:
  - state forced to NOT_STARTING next edge; all command, LED and power_off outputs 0.
  - Dividers cleared; mileage held.
  - rev_q still tracks reverse.
- FSM (enable=1), evaluated per edge. Priority within a cycle: power-off > brake > throttle/clutch.
  - NOT_STARTING:
    - throttle & !clutch -> power_off pulse, stay.
    - throttle & clutch & !brake -> STARTING.
    - else stay.
  - STARTING:
    - brake -> NOT_STARTING.
    - throttle & !clutch -> MOVING.
    - else stay.
  - MOVING:
    - rev_chg & !clutch -> power_off pulse, go NOT_STARTING.
    - brake -> NOT_STARTING.
    - !throttle | clutch -> STARTING.
    - else stay.
- Power off:
  - power_off is high exactly one cycle per event.
  - Events on consecutive cycles each pulse; the upstream power FSM drops enable.
- Latency: outputs are registered and decoded from next-state, so they change on the same edge as state (1 cycle after the input).
- move_forward = (state==MOVING) & !reverse. move_backward = (state==MOVING) & reverse. Never both high.
- brake_out = enable & brake in any state.
- Steering:
  - turn_left = enable & left & !right & (state!=NOT_STARTING).
  - turn_right is symmetric.
  - left & right together -> both 0.
- Turn LEDs:
  - The blink divider counts 0..BLINK_DIV-1 while enable=1, with wrap-around; on wrap a phase bit toggles.
  - left_led = left & phase; right_led = right & phase.
  - LEDs operate in every state, including NOT_STARTING.
- Mileage:
  - The divider counts only while state==MOVING; it holds its value in STARTING and clears in NOT_STARTING.
  - On reaching MILE_DIV-1, mileage increments by 1 and the divider clears.
  - mileage wraps modulo 2^MILE_W.
  - Only rst clears mileage.
- Mid-operation reset: rst asserted in any state returns everything to reset values immediately, with no power_off pulse.

Test Plan:
- Reset, enable=1, clutch=1, throttle=1 for 1 cycle -> state 00->01 next edge; then clutch=0 -> state=10, move_forward=1, move_backward=0.
- NOT_STARTING, throttle=1, clutch=0 -> power_off=1 for exactly 1 cycle, state stays 00, no motion outputs.
- MOVING forward, toggle reverse 0->1 with clutch=0 -> power_off 1-cycle pulse, state=00. Repeat with clutch=1 -> no pulse, state=01, move_backward=0 until re-entering MOVING, then move_backward=1.
- MOVING, brake=1 with throttle=1 -> state=00 next edge, brake_out=1, move_forward=0.
- BLINK_DIV=4, left=1 -> left_led toggles every 4 cycles; left=right=1 -> turn_left=turn_right=0, both LEDs blink.
- MILE_DIV=3, MILE_W=2, hold MOVING 12 cycles -> mileage 0,1,2,3,0 (wrap); drop to STARTING -> mileage holds; rst mid-MOVING -> mileage=0, state=00 asynchronously.
